// File: rtl/chirp_seq_pkg.sv
// Shared types and constants for the chirp pulse sequencer and its timers.
package chirp_seq_pkg;

  localparam int CNT_W    = 16;
  localparam int PERIOD_W = 32;

  localparam int DEF_DDS_LATENCY    = 2;
  localparam int DEF_MIN_GAP        = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1 << 20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ARM,
    S_PRE,
    S_CHIRP,
    S_POST,
    S_GAP,
    S_DONE
  } seq_state_e;

  typedef struct packed {
    logic [CNT_W-1:0]    num_pulses;
    logic [PERIOD_W-1:0] pulse_period;
    logic [CNT_W-1:0]    pre_capture;
    logic [CNT_W-1:0]    post_capture;
  } seq_cfg_t;

endpackage

// File: rtl/chirp_seq_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module chirp_seq_timer
  import chirp_seq_pkg::*;
#(
  parameter int W = PERIOD_W
) (
  input  logic         clk_245,
  input  logic         clk_245_rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk_245) begin
    if (clk_245_rst)         count <= '0;
    else if (load)           count <= load_val;
    else if (count != '0)    count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/chirp_pulse_sequencer.sv
// Burst sequencer for the chirp DDS and ADC capture path: paces pulses at a
// fixed PRI, stalls on FIFO backpressure, and guards ARM/CHIRP with a watchdog.
module chirp_pulse_sequencer
  import chirp_seq_pkg::*;
#(
  parameter int DDS_LATENCY    = DEF_DDS_LATENCY,
  parameter int MIN_GAP        = DEF_MIN_GAP,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                clk_245,
  input  logic                clk_245_rst,
  input  logic                seq_start,
  input  logic                seq_abort,
  input  logic [CNT_W-1:0]    num_pulses,
  input  logic [PERIOD_W-1:0] pulse_period,
  input  logic [CNT_W-1:0]    pre_capture,
  input  logic [CNT_W-1:0]    post_capture,
  input  logic                fifo_almost_full,
  input  logic                chirp_ready,
  input  logic                chirp_done,
  input  logic                chirp_active,
  output logic                chirp_init,
  output logic                chirp_enable,
  output logic                adc_enable,
  output logic                seq_busy,
  output logic                seq_done,
  output logic [CNT_W-1:0]    pulse_index,
  output logic                err_overrun,
  output logic                err_timeout,
  output logic                err_aborted
);

  localparam int XW = PERIOD_W + 2;

  seq_state_e          state, nxt;
  seq_cfg_t            cfg;
  logic [PERIOD_W-1:0] pcnt;
  logic [PERIOD_W-1:0] post_len;
  logic [PERIOD_W-1:0] win_val;
  logic [XW-1:0]       ovr_sum;
  logic                ovr;
  logic                start_ok;
  logic                win_load, win_zero;
  logic                wd_load, wd_zero;
  logic                active_q;
  logic                idx_inc, set_ovr, set_tmo, set_abt;

  assign start_ok = (state == S_IDLE) && seq_start && !seq_abort;
  assign post_len = PERIOD_W'(cfg.post_capture) + PERIOD_W'(DDS_LATENCY);

  // Overrun when the cycles already spent plus the mandatory gap reach the PRI;
  // widened so small periods cannot underflow.
  assign ovr_sum = XW'(pcnt) + XW'(MIN_GAP) + XW'(1);
  assign ovr     = (ovr_sum >= XW'(cfg.pulse_period));

  always_comb begin
    nxt     = state;
    idx_inc = 1'b0;
    set_tmo = 1'b0;
    set_abt = 1'b0;
    case (state)
      S_IDLE:  if (start_ok) nxt = S_INIT;
      S_INIT:  nxt = S_ARM;
      S_ARM:   if (chirp_ready && !fifo_almost_full)
                 nxt = (cfg.pre_capture == '0) ? S_CHIRP : S_PRE;
      S_PRE:   if (win_zero) nxt = S_CHIRP;
      S_CHIRP: if (chirp_done) nxt = S_POST;
      S_POST:  if (win_zero) begin
                 idx_inc = 1'b1;
                 if ((cfg.num_pulses != '0) && ((pulse_index + 16'd1) == cfg.num_pulses))
                   nxt = S_DONE;
                 else
                   nxt = S_GAP;
               end
      S_GAP:   if (win_zero) nxt = S_INIT;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase

    if ((state == S_ARM || state == S_CHIRP) && wd_zero) begin
      nxt     = S_DONE;
      set_tmo = 1'b1;
    end

    // Abort outranks every other transition, including a coincident chirp_done.
    if (state != S_IDLE && state != S_DONE && seq_abort) begin
      nxt     = S_DONE;
      idx_inc = 1'b0;
      set_tmo = 1'b0;
      set_abt = 1'b1;
    end
  end

  assign set_ovr = (state == S_POST) && (nxt == S_GAP) && ovr;

  // Window loads hold length-1 so the state lasts exactly the programmed cycles.
  always_comb begin
    win_load = (nxt != state) && (nxt inside {S_PRE, S_POST, S_GAP});
    win_val  = '0;
    case (nxt)
      S_PRE:   win_val = PERIOD_W'(cfg.pre_capture) - PERIOD_W'(1);
      S_POST:  win_val = (post_len == '0) ? '0 : post_len - PERIOD_W'(1);
      S_GAP:   win_val = ovr ? PERIOD_W'(MIN_GAP - 1)
                             : cfg.pulse_period - pcnt - PERIOD_W'(2);
      default: win_val = '0;
    endcase
  end

  // The watchdog restarts on any state change and once more when the DDS
  // reports activity, so only a chirp that never starts or never ends expires.
  assign wd_load = (nxt != state) || (state == S_CHIRP && chirp_active && !active_q);

  chirp_seq_timer #(.W(PERIOD_W)) u_win (
    .clk_245     (clk_245),
    .clk_245_rst (clk_245_rst),
    .load        (win_load),
    .load_val    (win_val),
    .zero        (win_zero)
  );

  chirp_seq_timer #(.W(PERIOD_W)) u_wdog (
    .clk_245     (clk_245),
    .clk_245_rst (clk_245_rst),
    .load        (wd_load),
    .load_val    (PERIOD_W'(TIMEOUT_CYCLES - 1)),
    .zero        (wd_zero)
  );

  always_ff @(posedge clk_245) begin
    if (clk_245_rst) begin
      state        <= S_IDLE;
      cfg          <= '0;
      pcnt         <= '0;
      active_q     <= 1'b0;
      pulse_index  <= '0;
      err_overrun  <= 1'b0;
      err_timeout  <= 1'b0;
      err_aborted  <= 1'b0;
      chirp_init   <= 1'b0;
      chirp_enable <= 1'b0;
      adc_enable   <= 1'b0;
      seq_busy     <= 1'b0;
      seq_done     <= 1'b0;
    end else begin
      state    <= nxt;
      active_q <= chirp_active;

      if (start_ok)
        cfg <= '{num_pulses: num_pulses, pulse_period: pulse_period,
                 pre_capture: pre_capture, post_capture: post_capture};

      if (nxt == S_INIT)    pcnt <= '0;
      else if (pcnt != '1)  pcnt <= pcnt + PERIOD_W'(1);

      if (start_ok)         pulse_index <= '0;
      else if (idx_inc)     pulse_index <= pulse_index + 16'd1;

      err_overrun <= !start_ok && (err_overrun || set_ovr);
      err_timeout <= !start_ok && (err_timeout || set_tmo);
      err_aborted <= !start_ok && (err_aborted || set_abt);

      chirp_init   <= (nxt == S_INIT);
      chirp_enable <= (nxt == S_CHIRP);
      adc_enable   <= (nxt inside {S_PRE, S_CHIRP, S_POST});
      seq_busy     <= (nxt != S_IDLE);
      seq_done     <= (nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_chirp_pulse_sequencer.sv
// Directed + randomized bench for chirp_pulse_sequencer with a timing model
// of whole pulses (INIT, ARM, capture window, gap) derived from the burst rules.
module tb_chirp_pulse_sequencer;

  localparam int DDS_LAT = 2;
  localparam int MIN_GAP = 4;
  localparam int TIMEOUT = 128;

  logic        clk_245 = 1'b0;
  logic        clk_245_rst = 1'b1;
  logic        seq_start = 1'b0, seq_abort = 1'b0;
  logic [15:0] num_pulses = '0, pre_capture = '0, post_capture = '0;
  logic [31:0] pulse_period = '0;
  logic        fifo_almost_full = 1'b0, chirp_ready = 1'b1;
  logic        chirp_done = 1'b0, chirp_active = 1'b0;
  logic        chirp_init, chirp_enable, adc_enable, seq_busy, seq_done;
  logic [15:0] pulse_index;
  logic        err_overrun, err_timeout, err_aborted;

  chirp_pulse_sequencer #(
    .DDS_LATENCY(DDS_LAT), .MIN_GAP(MIN_GAP), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk_245(clk_245), .clk_245_rst(clk_245_rst),
    .seq_start(seq_start), .seq_abort(seq_abort),
    .num_pulses(num_pulses), .pulse_period(pulse_period),
    .pre_capture(pre_capture), .post_capture(post_capture),
    .fifo_almost_full(fifo_almost_full), .chirp_ready(chirp_ready),
    .chirp_done(chirp_done), .chirp_active(chirp_active),
    .chirp_init(chirp_init), .chirp_enable(chirp_enable), .adc_enable(adc_enable),
    .seq_busy(seq_busy), .seq_done(seq_done), .pulse_index(pulse_index),
    .err_overrun(err_overrun), .err_timeout(err_timeout), .err_aborted(err_aborted)
  );

  always #5 clk_245 = ~clk_245;

  int total = 0, passed = 0;
  int cyc = 0, en_cnt = 0, clen = 1, done_cnt = 0, done_cyc = 0;
  bit adc_prev = 1'b0;
  int init_q[$], rise_q[$], fall_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [63:0] outs();
    return 64'({chirp_init, chirp_enable, adc_enable, seq_busy, seq_done,
                err_overrun, err_timeout, err_aborted, pulse_index});
  endfunction

  // One clock: sample at the falling edge, log events, and play the DDS
  // (chirp_done in the clen-th cycle of chirp_enable).
  task automatic step();
    @(posedge clk_245);
    cyc++;
    @(negedge clk_245);
    if (chirp_init) init_q.push_back(cyc);
    if (adc_enable && !adc_prev) rise_q.push_back(cyc);
    if (!adc_enable && adc_prev) fall_q.push_back(cyc);
    adc_prev = adc_enable;
    if (seq_done) begin done_cnt++; done_cyc = cyc; end
    en_cnt = chirp_enable ? en_cnt + 1 : 0;
    chirp_done   = chirp_enable && (en_cnt == clen);
    chirp_active = chirp_enable;
  endtask

  task automatic clear_log();
    init_q.delete(); rise_q.delete(); fall_q.delete();
    done_cnt = 0;
  endtask

  task automatic set_cfg(input int num, input int per, input int pre, input int post, input int cl);
    num_pulses = 16'(num); pulse_period = 32'(per);
    pre_capture = 16'(pre); post_capture = 16'(post); clen = cl;
  endtask

  // Full burst with ready DDS; optional FIFO stall (cycles into the burst) on pulse 0.
  task automatic run_burst(input string tag, input int num, input int per, input int pre,
                           input int post, input int cl, input int stall);
    int w, c0, n, arm, t, need, exp_sp, want_ovr;
    w = pre + cl + post + DDS_LAT;
    clear_log();
    set_cfg(num, per, pre, post, cl);
    fifo_almost_full = (stall > 1);
    seq_start = 1'b1; c0 = cyc; step(); seq_start = 1'b0;
    num_pulses = 16'($urandom); pulse_period = $urandom;
    pre_capture = 16'($urandom); post_capture = 16'($urandom);
    n = 0;
    while (done_cnt == 0 && n < 20000) begin
      if (n == stall) fifo_almost_full = 1'b0;
      seq_start = (n == 3);
      step(); n++;
    end
    seq_start = 1'b0; fifo_almost_full = 1'b0;
    check({tag, "_finished"}, 64'(done_cnt != 0), 64'(1));
    repeat (3) step();

    check({tag, "_n_inits"}, 64'(init_q.size()), 64'(num));
    t = c0 + 1; want_ovr = 0;
    for (int k = 0; k < num; k++) begin
      arm  = (k == 0 && stall > 1) ? stall : 1;
      need = arm + w + 1 + MIN_GAP;
      exp_sp = (need > per) ? need : per;
      if (k < init_q.size()) check({tag, "_init"}, 64'(init_q[k]), 64'(t));
      if (k < rise_q.size()) check({tag, "_adc_rise"}, 64'(rise_q[k]), 64'(t + arm + 1));
      if (k < fall_q.size()) check({tag, "_adc_fall"}, 64'(fall_q[k]), 64'(t + arm + 1 + w));
      if (k + 1 < num && need >= per) want_ovr = 1;
      t += exp_sp;
    end
    check({tag, "_pulse_index"}, 64'(pulse_index), 64'(num));
    check({tag, "_done_once"}, 64'(done_cnt), 64'(1));
    check({tag, "_overrun"}, 64'(err_overrun), 64'(want_ovr));
    check({tag, "_flags_idle"}, 64'({err_timeout, err_aborted, seq_busy}), 64'(0));
  endtask

  initial begin
    int c0, n;

    repeat (3) step();
    check("reset_outputs", outs(), 64'(0));
    clk_245_rst = 1'b0;
    step();

    run_burst("basic", 3, 200, 10, 20, 100, 0);

    // Watchdog: DDS never ready.
    chirp_ready = 1'b0;
    clear_log(); set_cfg(1, 200, 10, 20, 100);
    seq_start = 1'b1; c0 = cyc; step(); seq_start = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 1000) begin step(); n++; end
    check("tmo_finished", 64'(done_cnt != 0), 64'(1));
    check("tmo_done_cycle", 64'(done_cyc), 64'(c0 + 2 + TIMEOUT));
    check("tmo_flag", 64'(err_timeout), 64'(1));
    check("tmo_no_adc", 64'(rise_q.size()), 64'(0));
    check("tmo_pulse_index", 64'(pulse_index), 64'(0));
    chirp_ready = 1'b1;
    step();

    for (int r = 0; r < 3; r++)
      run_burst("rand", $urandom_range(1, 3), $urandom_range(20, 300), $urandom_range(0, 8),
                $urandom_range(0, 8), $urandom_range(1, 40), 0);

    run_burst("backpressure", 2, 200, 10, 40, 100, 50);

    // Abort 40 cycles into the second chirp.
    clear_log(); set_cfg(3, 200, 10, 20, 100);
    seq_start = 1'b1; step(); seq_start = 1'b0;
    n = 0;
    while (!(init_q.size() == 2 && en_cnt == 40) && n < 2000) begin step(); n++; end
    check("abort_reached_chirp", 64'(en_cnt), 64'(40));
    seq_abort = 1'b1; step(); seq_abort = 1'b0;
    check("abort_drive_low", 64'({chirp_enable, adc_enable}), 64'(0));
    check("abort_flag_done", 64'({err_aborted, seq_done}), 64'(3));
    check("abort_pulse_index", 64'(pulse_index), 64'(1));
    step();
    check("abort_idle", 64'({seq_busy, err_aborted}), 64'(1));

    // Continuous mode: chirp longer than the PRI, so every gap is the floor.
    clear_log(); set_cfg(0, 50, 5, 5, 60);
    seq_start = 1'b1; step(); seq_start = 1'b0;
    n = 0;
    while (init_q.size() < 5 && n < 2000) begin step(); n++; end
    check("cont_inits", 64'(init_q.size()), 64'(5));
    for (int k = 0; k < 4; k++) begin
      if (k < fall_q.size()) check("cont_gap", 64'(init_q[k+1] - fall_q[k]), 64'(MIN_GAP));
      check("cont_spacing", 64'(init_q[k+1] - init_q[k]), 64'(5 + 60 + 5 + DDS_LAT + 2 + MIN_GAP));
    end
    check("cont_overrun_busy", 64'({err_overrun, seq_busy}), 64'(3));
    check("cont_pulse_index", 64'(pulse_index), 64'(4));
    seq_abort = 1'b1; step(); seq_abort = 1'b0;
    check("cont_abort", 64'({seq_done, err_aborted, chirp_enable, adc_enable}), 64'(12));
    check("cont_abort_index", 64'(pulse_index), 64'(4));
    step();
    check("cont_idle", 64'(seq_busy), 64'(0));

    // Start together with abort in IDLE is ignored (errors stay sticky too).
    clear_log();
    seq_start = 1'b1; seq_abort = 1'b1; step();
    seq_start = 1'b0; seq_abort = 1'b0;
    repeat (3) step();
    check("start_abort_no_init", 64'(init_q.size()), 64'(0));
    check("start_abort_state", 64'({seq_busy, err_aborted}), 64'(1));

    // Reset in the middle of the POST window.
    clear_log(); set_cfg(2, 200, 10, 20, 100);
    seq_start = 1'b1; step(); seq_start = 1'b0;
    n = 0;
    while (en_cnt != 100 && n < 2000) begin step(); n++; end
    repeat (5) step();
    check("rst_in_post", 64'({chirp_enable, adc_enable}), 64'(1));
    clk_245_rst = 1'b1; step();
    check("rst_mid_outputs", outs(), 64'(0));
    clk_245_rst = 1'b0;
    repeat (10) step();
    check("rst_no_done", 64'(done_cnt), 64'(0));
    check("rst_stays_idle", 64'({seq_busy, adc_enable}), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
